// File: rtl/seq_pkg.sv
// Shared constants and types for the sequence_det serial pattern detector.
// The optional match counter is enabled by defining SEQ_DET_CNT_EN.
package seq_pkg;

   localparam int SEQ_LEN = 6;
   localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 6'b100011;

   typedef logic [SEQ_LEN-1:0] seq_win_t;

   // Width of a counter that must hold the values 0..n inclusive.
   function automatic int fill_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sequence_det_if.sv
// Serial stream port of sequence_det: one data bit and its valid strobe in,
// match pulse, window fill level and match count out.
interface sequence_det_if import seq_pkg::*; #(
   parameter int LEN   = SEQ_LEN,
   parameter int CNT_W = 8
);
   localparam int FILL_W = fill_width(LEN);

   // Handshake: I is consumed on every rising clk edge where I_valid is 1;
   // there is no ready, the detector accepts one bit per cycle indefinitely.
   logic              I;
   logic              I_valid;
   logic              O;
   logic [FILL_W-1:0] fill;
   logic [CNT_W-1:0]  match_cnt;

   modport master (output I, output I_valid, input O, input fill, input match_cnt);
   modport slave  (input I, input I_valid, output O, output fill, output match_cnt);

endinterface

// File: rtl/seq_shift_window.sv
// Window shift register and saturating fill counter for sequence_det.
// Exposes next-state values so the compare can act on the bit being sampled.
module seq_shift_window import seq_pkg::*; #(
   parameter int LEN    = SEQ_LEN,
   parameter int FILL_W = fill_width(LEN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic              fill_clr,
   input  logic              din,
   output logic [LEN-1:0]    win_next,
   output logic [FILL_W-1:0] fill_next,
   output logic [LEN-1:0]    win,
   output logic [FILL_W-1:0] fill
);
   logic [LEN-1:0]    win_q, win_d;
   logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

   // fill_next excludes the clear so the match compare never loops through it.
   always_comb begin
      win_d    = win_q;
      fill_inc = fill_q;
      if (shift_en) begin
         win_d = {win_q[LEN-2:0], din};
         if (fill_q != FILL_W'(LEN))
            fill_inc = fill_q + FILL_W'(1);
      end
      fill_d = fill_clr ? '0 : fill_inc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end

   assign win_next  = win_d;
   assign fill_next = fill_inc;
   assign win       = win_q;
   assign fill      = fill_q;

endmodule

// File: rtl/sequence_det.sv
// Serial pattern detector: pulses O one cycle after the last bit of PATTERN.
// Define SEQ_DET_CNT_EN to build the saturating match counter.
module sequence_det import seq_pkg::*; #(
   parameter int             LEN     = SEQ_LEN,
   parameter logic [LEN-1:0] PATTERN = LEN'(SEQ_PATTERN),
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  logic           clk,
   input  logic           reset,
   sequence_det_if.slave  bus
);
   localparam int FILL_W = fill_width(LEN);

   logic [LEN-1:0]    win_next, win;
   logic [FILL_W-1:0] fill_next, fill;
   logic              match, fill_clr;
   logic              o_q, o_d;

   seq_shift_window #(.LEN(LEN), .FILL_W(FILL_W)) u_window (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (bus.I_valid),
      .fill_clr  (fill_clr),
      .din       (bus.I),
      .win_next  (win_next),
      .fill_next (fill_next),
      .win       (win),
      .fill      (fill)
   );

   // Compare against the window as it will be after this edge's shift.
   always_comb begin
      match    = bus.I_valid && (fill_next == FILL_W'(LEN)) && (win_next == PATTERN);
      fill_clr = match && !OVERLAP;
      o_d      = match;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) o_q <= 1'b0;
      else        o_q <= o_d;
   end

   assign bus.O    = o_q;
   assign bus.fill = fill;

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (match && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bus.match_cnt = cnt_q;
`else
   assign bus.match_cnt = '0;
`endif

   logic unused_win;
   assign unused_win = ^win;

endmodule

// File: tb/tb_sequence_det.sv
// Directed bench for sequence_det: overlapping, non-overlapping and 2-bit
// counter instances share one stimulus stream.
module tb_sequence_det;
   import seq_pkg::*;

`ifdef SEQ_DET_CNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   logic clk;
   logic reset;
   logic din;
   logic vld;
   int   n_checks;
   int   n_pass;

   sequence_det_if #(.LEN(6), .CNT_W(8)) if_ov ();
   sequence_det_if #(.LEN(6), .CNT_W(8)) if_no ();
   sequence_det_if #(.LEN(6), .CNT_W(2)) if_c2 ();

   assign if_ov.I = din;
   assign if_ov.I_valid = vld;
   assign if_no.I = din;
   assign if_no.I_valid = vld;
   assign if_c2.I = din;
   assign if_c2.I_valid = vld;

   sequence_det #(.OVERLAP(1'b1), .CNT_W(8)) dut_ov (.clk(clk), .reset(reset), .bus(if_ov));
   sequence_det #(.OVERLAP(1'b0), .CNT_W(8)) dut_no (.clk(clk), .reset(reset), .bus(if_no));
   sequence_det #(.OVERLAP(1'b1), .CNT_W(2)) dut_c2 (.clk(clk), .reset(reset), .bus(if_c2));

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_o_ov"}, if_ov.O, 0);
      check({tag, "_fill_ov"}, if_ov.fill, 0);
      check({tag, "_cnt_ov"}, if_ov.match_cnt, 0);
      check({tag, "_o_no"}, if_no.O, 0);
      check({tag, "_fill_no"}, if_no.fill, 0);
      check({tag, "_cnt_c2"}, if_c2.match_cnt, 0);
   endtask

   // Assert reset mid-cycle, verify outputs clear at once, release on a negedge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      vld = 1'b0;
      reset = 1'b0;
      #2;
      check_all_zero(tag);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Drive n steps MSB first; after each edge compare O of every instance.
   task automatic send_seq(input string tag, input logic [15:0] bits, input logic [15:0] vm,
                           input int n, input logic [15:0] eo_ov, input logic [15:0] eo_no);
      for (int i = n - 1; i >= 0; i--) begin
         din = bits[i];
         vld = vm[i];
         @(posedge clk);
         @(negedge clk);
         check($sformatf("%s_o_ov[%0d]", tag, n - 1 - i), if_ov.O, eo_ov[i]);
         check($sformatf("%s_o_no[%0d]", tag, n - 1 - i), if_no.O, eo_no[i]);
         check($sformatf("%s_o_c2[%0d]", tag, n - 1 - i), if_c2.O, eo_ov[i]);
      end
      vld = 1'b0;
   endtask

   task automatic idle_cycle(input string tag);
      vld = 1'b0;
      din = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle_o_ov"}, if_ov.O, 0);
      check({tag, "_idle_o_no"}, if_no.O, 0);
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      reset = 1'b0;
      din = 1'b0;
      vld = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("por");
      reset = 1'b1;

      // Single pattern on consecutive cycles.
      send_seq("t1", 16'b100011, 16'h3f, 6, 16'b000001, 16'b000001);
      check("t1_fill_ov", if_ov.fill, 6);
      check("t1_fill_no", if_no.fill, 0);
      check("t1_cnt_ov", if_ov.match_cnt, CNT_EN);
      check("t1_cnt_c2", if_c2.match_cnt, CNT_EN);
      idle_cycle("t1");
      check("t1_hold_fill_ov", if_ov.fill, 6);

      // Three-cycle gap between bits 3 and 4; I toggled as don't-care.
      do_reset("r2");
      send_seq("t2", 16'b100111011, 16'b111000111, 9, 16'b000000001, 16'b000000001);
      check("t2_cnt_ov", if_ov.match_cnt, CNT_EN);

      // Overlap versus refill on 1,0,0,0,1,1,0,0,0,1,1.
      do_reset("r3");
      send_seq("t3a", 16'b100011, 16'h3f, 6, 16'b000001, 16'b000001);
      check("t3_fill_no_mid", if_no.fill, 0);
      check("t3_fill_ov_mid", if_ov.fill, 6);
      send_seq("t3b", 16'b00011, 16'h1f, 5, 16'b00001, 16'b00000);
      check("t3_fill_no_end", if_no.fill, 5);
      check("t3_fill_ov_end", if_ov.fill, 6);
      check("t3_cnt_ov", if_ov.match_cnt, 2 * CNT_EN);
      check("t3_cnt_no", if_no.match_cnt, CNT_EN);

      // Reset in mid-pattern discards the partial bits.
      do_reset("r4");
      send_seq("t4a", 16'b1000, 16'hf, 4, 16'b0000, 16'b0000);
      check("t4_fill_pre", if_ov.fill, 4);
      do_reset("r4mid");
      send_seq("t4b", 16'b11, 16'h3, 2, 16'b00, 16'b00);
      check("t4_fill_post", if_ov.fill, 2);
      check("t4_cnt_ov", if_ov.match_cnt, 0);

      // Two-bit counter saturates at 3.
      do_reset("r5");
      for (int k = 1; k <= 5; k++) begin
         send_seq($sformatf("t5_%0d", k), 16'b100011, 16'h3f, 6, 16'b000001, 16'b000001);
         check($sformatf("t5_cnt_c2_%0d", k), if_c2.match_cnt, (k < 3 ? k : 3) * CNT_EN);
      end
      idle_cycle("t5");
      check("t5_cnt_c2_hold", if_c2.match_cnt, 3 * CNT_EN);
      check("t5_cnt_ov", if_ov.match_cnt, 5 * CNT_EN);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
